// File: rtl/pwm_dac_sched.sv
// Slow-DAC PWM channel scheduler: round-robin write arbitration into clamped
// per-channel targets, with sync-aligned, optionally slew-limited output updates.
module pwm_dac_sched #(
    parameter logic [23:0] PWM_MAX = 24'h9C0000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             sync_i,
    input  logic [23:0]      slew_i,
    input  logic             r0_valid_i,
    output logic             r0_ready_o,
    input  logic [1:0]       r0_ch_i,
    input  logic [23:0]      r0_dat_i,
    input  logic             r1_valid_i,
    output logic             r1_ready_o,
    input  logic [1:0]       r1_ch_i,
    input  logic [23:0]      r1_dat_i,
    output logic [23:0]      pwm_a_o,
    output logic [23:0]      pwm_b_o,
    output logic [23:0]      pwm_c_o,
    output logic [23:0]      pwm_d_o,
    output logic             busy_o,
    output logic             clamp_o,
    output logic [CNT_W-1:0] wr_cnt_o
);

    logic             r_last1;
    logic [23:0]      r_tgt [4];
    logic [23:0]      r_out [4];
    logic             r_busy;
    logic             r_clamp;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer;
    logic [1:0]       w_ch;
    logic [23:0]      w_dat;
    logic             w_over;
    logic [23:0]      w_wval;
    logic [23:0]      w_tgt_nx [4];
    logic [23:0]      w_out_nx [4];
    logic [23:0]      w_diff   [4];
    logic             w_busy_nx;

    // r_last1 high means r1 was granted last, so r0 wins the next tie.
    always_comb begin
        w_gnt0     = r0_valid_i & (~r1_valid_i | r_last1);
        w_gnt1     = r1_valid_i & ~w_gnt0;
        r0_ready_o = w_gnt0 & rstn_i;
        r1_ready_o = w_gnt1 & rstn_i;
        w_xfer     = r0_ready_o | r1_ready_o;
        w_ch       = w_gnt0 ? r0_ch_i  : r1_ch_i;
        w_dat      = w_gnt0 ? r0_dat_i : r1_dat_i;
        w_over     = (w_dat > PWM_MAX);
        w_wval     = w_over ? PWM_MAX : w_dat;
    end

    // Sync step reads pre-write targets; a coincident write lands at the next sync.
    always_comb begin
        w_busy_nx = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_tgt_nx[i] = (w_xfer && (w_ch == i[1:0])) ? w_wval : r_tgt[i];
            w_diff[i]   = '0;
            w_out_nx[i] = r_out[i];
            if (sync_i) begin
                if (slew_i == '0) begin
                    w_out_nx[i] = r_tgt[i];
                end else if (r_tgt[i] > r_out[i]) begin
                    w_diff[i]   = r_tgt[i] - r_out[i];
                    w_out_nx[i] = (slew_i >= w_diff[i]) ? r_tgt[i] : r_out[i] + slew_i;
                end else if (r_tgt[i] < r_out[i]) begin
                    w_diff[i]   = r_out[i] - r_tgt[i];
                    w_out_nx[i] = (slew_i >= w_diff[i]) ? r_tgt[i] : r_out[i] - slew_i;
                end
            end
            if (w_out_nx[i] != w_tgt_nx[i]) begin
                w_busy_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last1 <= 1'b1;
            r_busy  <= 1'b0;
            r_clamp <= 1'b0;
            r_cnt   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_tgt[i] <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_busy  <= w_busy_nx;
            r_clamp <= w_xfer & w_over;
            if (w_xfer) begin
                r_last1 <= w_gnt1;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            for (int unsigned i = 0; i < 4; i++) begin
                r_tgt[i] <= w_tgt_nx[i];
                r_out[i] <= w_out_nx[i];
            end
        end
    end

    assign pwm_a_o  = r_out[0];
    assign pwm_b_o  = r_out[1];
    assign pwm_c_o  = r_out[2];
    assign pwm_d_o  = r_out[3];
    assign busy_o   = r_busy;
    assign clamp_o  = r_clamp;
    assign wr_cnt_o = r_cnt;

endmodule

// File: doc/pwm_dac_sched.md
Name: pwm_dac_sched

Overview:
- Controller for the four slow-DAC PWM channel inputs of the analog interface.
- Accepts channel writes from two requesters (register bus and sweep/feedback engine) through a round-robin arbiter, into per-channel target registers.
- Targets are clamped to the 100% PWM code.
- Drives the 24-bit PWM channel inputs only on the PWM sync pulse, optionally slew-limited, so a channel never changes mid-cycle.

Parameters:
- PWM_MAX, 24'h9C0000: largest legal channel code ({8'd156,16'h0}, 100% duty); larger writes clamp to this.
- CNT_W, 16: width of accepted-write counter.

Ports:
- clk_i  in  1  system clock (ADC clock domain)
- rstn_i  in  1  reset; one clock, asynchronous assert, active-low
- sync_i  in  1  PWM sync pulse, single-cycle, already synchronised to clk_i
- slew_i  in  24  max change per sync per channel; 0 = immediate update
- r0_valid_i  in  1  requester 0 write request
- r0_ready_o  out  1  requester 0 grant/accept
- r0_ch_i  in  2  requester 0 channel (0=a,1=b,2=c,3=d)
- r0_dat_i  in  24  requester 0 value (upper 8 = integer duty, lower 16 = dither bits)
- r1_valid_i, r1_ready_o, r1_ch_i, r1_dat_i  as requester 0
- pwm_a_o, pwm_b_o, pwm_c_o, pwm_d_o  out  24  registered channel values to analog block
- busy_o  out  1  registered; high while any pwm_x_o != its target
- clamp_o  out  1  registered one-cycle pulse when an accepted write was clamped
- wr_cnt_o  out  CNT_W  accepted writes since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (rstn_i low, async):
  - targets, pwm_*_o, busy_o, clamp_o and wr_cnt_o go to 0.
  - Round-robin pointer set so r0 wins the first tie.
  - ready outputs forced 0.
  - In-flight requests are dropped, not queued.
- Handshake:
  - rX_ready_o is combinational from the valids and the pointer.
  - A transfer occurs when valid && ready in the same cycle.
  - At most one transfer per cycle.
  - A requester holds valid/ch/dat stable until accepted.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: the requester not granted last is granted; the pointer updates only on a transfer.
  - No starvation: each requester waits at most one transfer.
- Write path, 1-cycle latency:
  - Transfer in cycle N → target[ch] = min(dat, PWM_MAX) at N+1.
  - clamp_o pulses at N+1 if dat > PWM_MAX.
  - wr_cnt_o increments at N+1.
- Sync update (sync_i high in cycle M), per channel, using targets and outputs as of cycle M; result visible at M+1:
  - slew_i == 0: out <= target.
  - target > out: out <= out + min(slew_i, target-out).
  - target < out: out <= out - min(slew_i, out-target).
  - Equal: unchanged.
  - Arithmetic is 24-bit unsigned; min() guarantees no overshoot and no wrap.
- pwm_*_o changes only in the cycle after sync_i. Writes never alter outputs directly.
- Simultaneous write and sync in cycle M: the sync uses the old target; the new target takes effect at the next sync.
- Two writes to the same channel before a sync: the last accepted write wins.
- busy_o is registered, computed from next-state values: it reflects (out != target) for the state visible in the same cycle.
- slew_i is sampled only on sync cycles; changes between syncs take effect at the next sync.

Test Plan:
- Reset, then r0 writes ch1=24'h4E0000, no sync → pwm_b_o stays 0, busy_o=1 at N+1, wr_cnt_o=1. Pulse sync_i with slew_i=0 → pwm_b_o=24'h4E0000 next cycle, busy_o=0.
- Both requesters valid for 4 cycles, r0 ch0 and r1 ch2 → grants alternate r0,r1,r0,r1. Each requester drops valid after 2 accepts. Final targets equal the last data from each; wr_cnt_o=4.
- r1 writes ch3=24'hFF0000 → clamp_o pulses once, target=24'h9C0000. After sync, pwm_d_o=24'h9C0000.
- slew_i=24'h100000, target ch0 0→24'h350000 → after successive syncs pwm_a_o=10_0000, 20_0000, 30_0000, 35_0000, then holds. busy_o falls with the last step. Repeat downward to 0 and check symmetric steps.
- Write ch2 in the same cycle as sync_i → pwm_c_o unchanged at M+1; takes the new value after the next sync.
- Assert rstn_i low mid-slew with r0_valid_i high → outputs and counters 0 immediately (async), ready=0. After release the held request is accepted on the first clock.
